// File: rtl/primegen_seek.sv
// primegen_seek: steps through primes on go, or seeks the smallest prime >= start on load.
// Build option: define PRIMEGEN_ODD_SKIP_EN to skip even candidates and even divisors.
module primegen_seek #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             load,
    input  logic [WIDTH-1:0] start,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] res
);

    localparam int CW = $clog2(WIDTH) + 1;

`ifdef PRIMEGEN_ODD_SKIP_EN
    localparam logic [WIDTH:0]     C_STEP  = (WIDTH+1)'(2);
    localparam logic [WIDTH-1:0]   D_INIT  = WIDTH'(3);
    localparam logic [WIDTH-1:0]   D_STEP  = WIDTH'(2);
    localparam logic [2*WIDTH-1:0] SQ_INIT = (2*WIDTH)'(9);
    localparam bit                 ODD_SKIP = 1'b1;
`else
    localparam logic [WIDTH:0]     C_STEP  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0]   D_INIT  = WIDTH'(2);
    localparam logic [WIDTH-1:0]   D_STEP  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] SQ_INIT = (2*WIDTH)'(4);
    localparam bit                 ODD_SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_PREP,
        S_CHECK,
        S_DIV,
        S_TEST
    } state_t;

    state_t             state_q;
    logic               ready_q;
    logic               error_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   c_q;
    logic [WIDTH-1:0]   d_q;
    logic [2*WIDTH-1:0] sq_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH:0]     succ_res_d;
    logic [WIDTH:0]     adv_c_d;
    logic [WIDTH-1:0]   d_adv_d;
    logic [2*WIDTH-1:0] sq_adv_d;
    logic [2*WIDTH-1:0] d_wide_d;
    logic [WIDTH:0]     rem_sh_d;
    logic [WIDTH-1:0]   rem_sub_d;
    logic               rem_ge_d;

    // Successor candidates (carry bit flags overflow), divisor/square stepping, divider step.
    always_comb begin
        succ_res_d = {1'b0, res_q} + C_STEP;
        adv_c_d    = {1'b0, c_q} + C_STEP;
        d_adv_d    = d_q + D_STEP;
        d_wide_d   = {{WIDTH{1'b0}}, d_q};
        // (d+2)^2 = d^2 + 4d + 4, (d+1)^2 = d^2 + 2d + 1
        if (ODD_SKIP) begin
            sq_adv_d = sq_q + (d_wide_d << 2) + (2*WIDTH)'(4);
        end else begin
            sq_adv_d = sq_q + (d_wide_d << 1) + (2*WIDTH)'(1);
        end
        rem_sh_d  = {rem_q, quo_q[WIDTH-1]};
        rem_ge_d  = (rem_sh_d >= {1'b0, d_q});
        // Result is < d whenever it is used, so the truncated difference is exact.
        rem_sub_d = rem_sh_d[WIDTH-1:0] - d_q;
    end

    // Control FSM with registered handshake, error and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            res_q   <= WIDTH'(1);
            c_q     <= '0;
            d_q     <= '0;
            sq_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        c_q     <= start;
                        error_q <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= S_PREP;
                    end else if (go && !error_q) begin
                        ready_q <= 1'b0;
                        state_q <= S_NEXT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_NEXT: begin
                    d_q  <= D_INIT;
                    sq_q <= SQ_INIT;
                    if (res_q == WIDTH'(1)) begin
                        c_q     <= WIDTH'(2);
                        state_q <= S_CHECK;
                    end else if (res_q == WIDTH'(2)) begin
                        c_q     <= WIDTH'(3);
                        state_q <= S_CHECK;
                    end else if (succ_res_d[WIDTH]) begin
                        error_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        c_q     <= succ_res_d[WIDTH-1:0];
                        state_q <= S_CHECK;
                    end
                end
                S_PREP: begin
                    d_q  <= D_INIT;
                    sq_q <= SQ_INIT;
                    if (c_q <= WIDTH'(1)) begin
                        res_q   <= WIDTH'(1);
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (c_q == WIDTH'(2)) begin
                        res_q   <= WIDTH'(2);
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (ODD_SKIP && !c_q[0]) begin
                        // An even value plus one cannot exceed the all-ones maximum.
                        c_q     <= {c_q[WIDTH-1:1], 1'b1};
                        state_q <= S_CHECK;
                    end else begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (sq_q > {{WIDTH{1'b0}}, c_q}) begin
                        res_q   <= c_q;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        rem_q   <= '0;
                        quo_q   <= c_q;
                        cnt_q   <= '0;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (rem_ge_d) begin
                        rem_q <= rem_sub_d;
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh_d[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_TEST;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_TEST: begin
                    if (rem_q == '0) begin
                        if (adv_c_d[WIDTH]) begin
                            error_q <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            c_q     <= adv_c_d[WIDTH-1:0];
                            d_q     <= D_INIT;
                            sq_q    <= SQ_INIT;
                            state_q <= S_CHECK;
                        end
                    end else begin
                        d_q     <= d_adv_d;
                        sq_q    <= sq_adv_d;
                        state_q <= S_CHECK;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign error = error_q;
    assign res   = res_q;

endmodule

// File: tb/tb_primegen_seek.sv
// Directed scoreboard bench for primegen_seek: a 16-bit and an 8-bit instance share clock and reset.
module tb_primegen_seek;

    logic        clk = 1'b0;
    logic        rst;
    logic        go16, load16, go8, load8;
    logic [15:0] start16, res16;
    logic [7:0]  start8, res8;
    logic        ready16, error16, ready8, error8;

    int checks = 0;
    int errors = 0;
    int total16 = 0;

    typedef struct {
        logic [15:0] res;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    primegen_seek #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .go(go16), .load(load16), .start(start16),
        .ready(ready16), .error(error16), .res(res16)
    );

    primegen_seek #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .go(go8), .load(load8), .start(start8),
        .ready(ready8), .error(error8), .res(res8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ready(input bit w8);
        return w8 ? ready8 : ready16;
    endfunction

    // One request: push expectation, pulse go/load, wait for ready, pop and compare.
    task automatic req(input bit w8, input bit g, input bit l, input logic [15:0] st,
                       input logic [15:0] exp_res, input bit exp_err, input string tag,
                       output int low);
        exp_t e;
        low = 0;
        @(negedge clk);
        chk({tag, "_ready_before"}, {31'd0, cur_ready(w8)}, 32'd1);
        sb.push_back('{res: exp_res, err: exp_err});
        if (w8) begin
            go8 = g; load8 = l; start8 = st[7:0];
        end else begin
            go16 = g; load16 = l; start16 = st;
        end
        @(negedge clk);
        go8 = 1'b0; load8 = 1'b0; go16 = 1'b0; load16 = 1'b0;
        chk({tag, "_ready_fell"}, {31'd0, cur_ready(w8)}, 32'd0);
        low = 1;
        while (!cur_ready(w8) && low < 20000) begin
            @(negedge clk);
            if (!cur_ready(w8)) low++;
        end
        if (!cur_ready(w8)) chk({tag, "_timeout"}, {31'd0, cur_ready(w8)}, 32'd1);
        e = sb.pop_front();
        if (w8) begin
            chk({tag, "_res"}, {24'd0, res8}, {16'd0, e.res});
            chk({tag, "_err"}, {31'd0, error8}, {31'd0, e.err});
        end else begin
            chk({tag, "_res"}, {16'd0, res16}, {16'd0, e.res});
            chk({tag, "_err"}, {31'd0, error16}, {31'd0, e.err});
        end
    endtask

    initial begin
        logic [15:0] seq [12];
        int low;
        seq = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17, 16'd19,
                16'd23, 16'd29, 16'd31, 16'd37};
        rst = 1'b1;
        go16 = 1'b0; load16 = 1'b0; start16 = 16'd0;
        go8 = 1'b0; load8 = 1'b0; start8 = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready16}, 32'd1);
        chk("rst_error", {31'd0, error16}, 32'd0);
        chk("rst_res", {16'd0, res16}, 32'd1);
        chk("rst_res8", {24'd0, res8}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            req(1'b0, 1'b1, 1'b0, 16'd0, seq[i], 1'b0, $sformatf("seq%0d", i), low);
            total16 += low;
            if (i == 0) chk("seq_first_low_cycles", low, 32'd2);
            if (i == 1) chk("seq_second_low_cycles", low, 32'd2);
        end
        $display("info: cycles with ready low over 12-step prime run: %0d", total16);

        req(1'b0, 1'b0, 1'b1, 16'd90, 16'd97, 1'b0, "load90", low);
        req(1'b0, 1'b1, 1'b0, 16'd0, 16'd101, 1'b0, "go101", low);
        req(1'b0, 1'b0, 1'b1, 16'd0, 16'd1, 1'b0, "load0", low);
        req(1'b0, 1'b1, 1'b0, 16'd0, 16'd2, 1'b0, "go_from1", low);
        chk("go_from1_low_cycles", low, 32'd2);
        req(1'b0, 1'b1, 1'b1, 16'd20, 16'd23, 1'b0, "go_load_both", low);
        req(1'b0, 1'b0, 1'b1, 16'd1, 16'd1, 1'b0, "load1", low);
        req(1'b0, 1'b0, 1'b1, 16'd65521, 16'd65521, 1'b0, "load_max_prime16", low);

        req(1'b1, 1'b0, 1'b1, 16'd251, 16'd251, 1'b0, "w8_load251", low);
        req(1'b1, 1'b1, 1'b0, 16'd0, 16'd251, 1'b1, "w8_overflow", low);
        @(negedge clk);
        go8 = 1'b1;
        @(negedge clk);
        go8 = 1'b0;
        chk("w8_ignored_ready", {31'd0, ready8}, 32'd1);
        chk("w8_ignored_error", {31'd0, error8}, 32'd1);
        chk("w8_ignored_res", {24'd0, res8}, 32'd251);
        req(1'b1, 1'b0, 1'b1, 16'd2, 16'd2, 1'b0, "w8_load2", low);
        req(1'b1, 1'b0, 1'b1, 16'd200, 16'd211, 1'b0, "w8_load200", low);

        @(negedge clk);
        load16 = 1'b1; start16 = 16'd1000;
        @(negedge clk);
        load16 = 1'b0;
        repeat (5) @(negedge clk);
        chk("midsearch_busy", {31'd0, ready16}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_res", {16'd0, res16}, 32'd1);
        chk("midrst_ready", {31'd0, ready16}, 32'd1);
        chk("midrst_error", {31'd0, error16}, 32'd0);
        req(1'b0, 1'b1, 1'b0, 16'd0, 16'd2, 1'b0, "after_rst_go", low);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
